// File: rtl/serial_defs.sv
// Framing constants and bit-level FSM encodings shared by the serial transmitter and receiver.
// No logic, no latency, no flow control.
package serial_defs;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/serial_receiver.sv
// Recovers framed bytes (start, 8 data LSB first, stop) from a synchronized serial line.
// Latency: 2-cycle synchronizer, then byte_valid/byte_err pulse at the mid-stop-bit sample.
// No backpressure: byte_valid is a one-cycle strobe that the consumer must take.
module serial_receiver
    import serial_defs::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] byte_data,
    output logic                 byte_valid,
    output logic                 byte_err,
    output logic                 rx_active
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 sync1_q, sync2_q, rx_prev_q;
    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;

    // rx_prev_q trails the synchronized line by one cycle for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            sync1_q   <= rx_serial;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_prev_q && !sync2_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = (sync2_q == START_BIT) ? DATA : IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d     = '0;
                    shift_d   = {sync2_q, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d = '0;
                    if (sync2_q == STOP_BIT) begin
                        byte_valid = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        byte_err = 1'b1;
                        state_d  = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (sync2_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_data = shift_q;
    assign rx_active = (state_q != IDLE);

endmodule

// File: rtl/data_receiver.sv
// Assembles BYTES_PER_WORD serial bytes (first byte in [7:0]) into one word with gap and frame checking.
// Latency: out_valid rises 2 cycles after the last byte's stop-bit sample.
// Backpressure: a completed word finding out_valid set and out_ready low is dropped with an overrun pulse.
module data_receiver
    import serial_defs::*;
#(
    parameter int CLKS_PER_BIT   = 16,
    parameter int BYTES_PER_WORD = 8,
    parameter int GAP_TIMEOUT    = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx_serial,
    output logic [8*BYTES_PER_WORD-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        frame_error,
    output logic                        overrun
);

    localparam int WW = 8 * BYTES_PER_WORD;
    localparam int KW = $clog2(BYTES_PER_WORD);
    localparam int GW = $clog2(GAP_TIMEOUT + 1);
    localparam logic [KW-1:0] LAST_BYTE = KW'(BYTES_PER_WORD - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TIMEOUT - 1);

    logic [DATA_BITS-1:0] byte_data;
    logic                 byte_valid, byte_err, rx_active;

    logic [KW-1:0] k_q, k_d;
    logic [WW-1:0] asm_q, asm_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          done_q, done_d;
    logic [WW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          frame_error_q, frame_error_d;
    logic          overrun_q, overrun_d;
    logic          gap_timeout;

    serial_receiver #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_serial_receiver (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_serial  (rx_serial),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_err   (byte_err),
        .rx_active  (rx_active)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q           <= '0;
            asm_q         <= '0;
            gap_q         <= '0;
            done_q        <= 1'b0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            k_q           <= k_d;
            asm_q         <= asm_d;
            gap_q         <= gap_d;
            done_q        <= done_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    // Gap timer only runs between bytes of a partial word; any start detection leaves IDLE and clears it.
    assign gap_timeout = (k_q != '0) && !rx_active && (gap_q == GAP_LAST);

    always_comb begin
        k_d           = k_q;
        asm_d         = asm_q;
        gap_d         = gap_q;
        done_d        = 1'b0;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;

        if (rx_active || (k_q == '0) || gap_timeout) begin
            gap_d = '0;
        end else begin
            gap_d = gap_q + 1'b1;
        end

        if (byte_err || gap_timeout) begin
            k_d           = '0;
            asm_d         = '0;
            frame_error_d = 1'b1;
        end else if (byte_valid) begin
            asm_d[int'(k_q)*8 +: 8] = byte_data;
            if (k_q == LAST_BYTE) begin
                k_d    = '0;
                done_d = 1'b1;
            end else begin
                k_d = k_q + 1'b1;
            end
        end

        // Acceptance is applied first so a same-cycle load leaves out_valid set with the new word.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (done_q) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = asm_q;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;
    assign busy        = (k_q != '0) || rx_active;

endmodule

// File: tb/tb_data_receiver.sv
// Directed bench for data_receiver: serial words in, assembled words and error pulses checked.
module tb_data_receiver;

    localparam int CPB = 16;

    logic        clk;
    logic        rst_n;
    logic        rx_serial;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        frame_error;
    logic        overrun;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          acc_cnt  = 0;
    int          fe_cnt   = 0;
    int          ov_cnt   = 0;
    logic [63:0] last_word = '0;

    data_receiver #(
        .CLKS_PER_BIT   (CPB),
        .BYTES_PER_WORD (8),
        .GAP_TIMEOUT    (1024)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_serial   (rx_serial),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                acc_cnt   = acc_cnt + 1;
                last_word = out_data;
            end
            if (frame_error) fe_cnt = fe_cnt + 1;
            if (overrun)     ov_cnt = ov_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_serial = b;
        wait_clks(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        rx_serial = 1'b1;
    endtask

    task automatic send_bytes(input logic [63:0] w, input int n);
        for (int i = 0; i < n; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic word_test(input string tag, input logic [63:0] w);
        int a0, f0;
        a0 = acc_cnt;
        f0 = fe_cnt;
        send_bytes(w, 8);
        wait_clks(40);
        check({tag, "_accepts"}, 64'(acc_cnt - a0), 64'd1);
        check({tag, "_word"}, last_word, w);
        check({tag, "_no_ferr"}, 64'(fe_cnt - f0), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    localparam logic [63:0] WORD_A = 64'hA1B2C3D4E5F60718;
    localparam logic [63:0] WORD_B = 64'h5566778899AABBCC;
    localparam logic [63:0] WORD_P = 64'h0F1E2D3C4B5A6978;

    initial begin
        int a0, f0, o0;
        rst_n     = 1'b0;
        rx_serial = 1'b1;
        out_ready = 1'b1;
        #23;
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_error", 64'(frame_error), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(20);

        // Back-to-back word with the sink always ready.
        o0 = ov_cnt;
        word_test("basic", 64'h0123456789ABCDEF);
        check("basic_no_overrun", 64'(ov_cnt - o0), 64'd0);

        // Overrun: sink stalled across two words.
        out_ready = 1'b0;
        o0 = ov_cnt;
        a0 = acc_cnt;
        send_bytes(WORD_A, 8);
        wait_clks(40);
        check("ovr_first_valid", 64'(out_valid), 64'd1);
        check("ovr_first_data", out_data, WORD_A);
        send_bytes(WORD_B, 8);
        wait_clks(40);
        check("ovr_pulse", 64'(ov_cnt - o0), 64'd1);
        check("ovr_data_held", out_data, WORD_A);
        check("ovr_valid_held", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        wait_clks(1);
        check("ovr_valid_cleared", 64'(out_valid), 64'd0);
        check("ovr_accepts", 64'(acc_cnt - a0), 64'd1);
        check("ovr_accepted_word", last_word, WORD_A);

        // Gap timeout after a partial word.
        f0 = fe_cnt;
        a0 = acc_cnt;
        send_bytes(64'h0000000000332211, 3);
        wait_clks(1000);
        check("gap_no_early_ferr", 64'(fe_cnt - f0), 64'd0);
        check("gap_busy_partial", 64'(busy), 64'd1);
        wait_clks(100);
        check("gap_ferr", 64'(fe_cnt - f0), 64'd1);
        check("gap_busy_cleared", 64'(busy), 64'd0);
        check("gap_no_word", 64'(acc_cnt - a0), 64'd0);
        word_test("after_gap", 64'h1122334455667788);

        // Bad stop bit on the fifth byte.
        f0 = fe_cnt;
        a0 = acc_cnt;
        send_bytes(WORD_P, 4);
        send_byte(WORD_P[39:32], 1'b0);
        wait_clks(40);
        check("stop_ferr", 64'(fe_cnt - f0), 64'd1);
        check("stop_no_word", 64'(acc_cnt - a0), 64'd0);
        check("stop_out_valid", 64'(out_valid), 64'd0);
        check("stop_busy", 64'(busy), 64'd0);
        word_test("after_stop", 64'h8877665544332211);

        // Short low glitch must be rejected at the half-bit re-sample.
        f0 = fe_cnt;
        a0 = acc_cnt;
        rx_serial = 1'b0;
        wait_clks(3);
        rx_serial = 1'b1;
        wait_clks(40);
        check("glitch_no_ferr", 64'(fe_cnt - f0), 64'd0);
        check("glitch_no_word", 64'(acc_cnt - a0), 64'd0);
        check("glitch_busy", 64'(busy), 64'd0);

        // Reset in the middle of the sixth byte.
        send_bytes(64'h0000001234567890, 5);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_out_data", out_data, 64'd0);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_frame_error", 64'(frame_error), 64'd0);
        check("mid_rst_overrun", 64'(overrun), 64'd0);
        rx_serial = 1'b1;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(40);
        word_test("after_rst", 64'hDEADBEEFCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
